count_uart_tx: RTL
==================

# count_uart_tx

Serializes 8-bit count values onto a single-wire UART line (8N1, LSB first). It is the stage directly downstream of the free-running 8-bit counter: the counter's value is offered on a valid/ready input and transmitted off-chip on one dedicated output pin. It accepts one byte per frame. It has no buffering beyond the frame shift register.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range is 2 to 65535.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  byte to transmit, normally the counter value.
- in_valid  input  1  in_data is offered this cycle.
- in_ready  output  1  block can accept a byte this cycle.
- tx  output  1  UART line; idle level is high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation

- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, tx=1, in_ready=1, busy=0, done=0, bit timer=0, bit index=0, shift register=0.
- States:
  - IDLE: tx=1, in_ready=1.
  - START: tx=0.
  - DATA: tx=shift[0].
  - STOP: tx=1.
- Transitions:
  - IDLE -> START on in_valid && in_ready. in_data is latched into the shift register at the same edge.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: shifts right every CLKS_PER_BIT cycles. After the 8th bit it moves to STOP.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Bit timer:
  - Counts 0 to CLKS_PER_BIT-1.
  - Its width is $clog2(CLKS_PER_BIT).
  - It resets to 0 on every state change.
  - The bit boundary is timer == CLKS_PER_BIT-1.
- Bit index: 3 bits, 0 to 7. The DATA state exits when index==7 at a bit boundary.
- in_ready=1 only in IDLE.
- busy is the inverse of in_ready.
- in_valid while busy is ignored. Nothing is queued, and the byte is lost unless the upstream stage holds it.
- Changes to in_data after acceptance have no effect on the frame in progress.
- tx is driven from a register, so it carries no combinational glitches.
- Reset asserted mid-frame: tx goes to 1 immediately, and the frame is aborted and not resumed.

## Timing

- Byte accepted at edge T:
  - tx=0 during cycles T+1 to T+N, where N=CLKS_PER_BIT.
  - Data bit k occupies cycles T+1+(k+1)N to T+(k+2)N.
  - The stop bit occupies cycles T+1+9N to T+10N.
- done=1 only in cycle T+10N.
- in_ready=1 again from cycle T+10N+1.
- If in_valid is held high, the next accept happens at edge T+10N+1. Back-to-back frames are separated by exactly one idle-high cycle.
- Frame period under continuous valid: 10N+1 cycles.
- Latency from acceptance to the falling edge of tx: 1 cycle.

## Structure

- Package count_uart_pkg contains:
  - typedef enum state_t {IDLE, START, DATA, STOP};
  - FRAME_DATA_BITS = 8;
  - TX_IDLE_LEVEL = 1'b1.
- One sub-module, uart_bit_timer:
  - Parameterized by CLKS_PER_BIT.
  - Input: clear. Output: bit_end, a one-cycle pulse at the bit boundary.
  - The FSM, shift register and bit index stay in count_uart_tx.

## Test plan

- Reset values: hold rst_n=0 -> tx=1, in_ready=1, busy=0, done=0.
- Basic frame: N=4, in_data=0xA5 pulsed valid for 1 cycle at edge T -> tx is:
  - 0 for 4 cycles;
  - then 1,0,1,0,0,1,0,1, each held for 4 cycles;
  - then 1 for 4 cycles.
  - done is high only in cycle T+40, and in_ready returns at T+41.
- Data held during frame: change in_data to 0xFF two cycles after acceptance of 0x00, with valid held low -> the frame carries 0x00 (all data bits 0); no second frame starts.
- Back-to-back: N=4, in_valid held high with in_data=0x01, then 0x02 -> the two frames start at edges T and T+41, with exactly 1 idle-high cycle between the stop bit and the next start bit.
- Mid-frame reset: assert rst_n=0 during data bit 3 of 0x3C -> tx=1 before the next clock edge. After release, in_ready=1 and no partial frame resumes.
- Minimum N: CLKS_PER_BIT=2, in_data=0x80 -> total frame of 20 cycles, bit 7 high for 2 cycles, done in cycle T+20.

Source files
------------

// File: rtl/count_uart_pkg.sv
// rtl/count_uart_pkg.sv - shared types and constants for the count UART transmitter
package count_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic TX_IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle timer, pulses bit_end_o on the last cycle of each bit
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  // Wrapping at the boundary keeps consecutive DATA bits aligned without a state change.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - 8N1 LSB-first UART transmitter for counter values, one byte per frame
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       tx_q, tx_d;
  logic       bit_end;
  logic       timer_clear;

  assign in_ready    = (state_q == IDLE);
  assign busy        = ~in_ready;
  assign tx          = tx_q;
  assign timer_clear = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clear),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = START;
          shift_d = in_data;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'(FRAME_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state so tx leaves a flop and changes on the edge.
  always_comb begin
    tx_d = TX_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = ~TX_IDLE_LEVEL;
      DATA:    tx_d = shift_d[0];
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= TX_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

endmodule
